// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory
// address and fills the IF/ID register, with stall, redirect and BREAK halt.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] BREAK_WORD = 32'h0000_000D
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_data,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pc_plus4;
    logic [31:0] inst_n, pc4_n, count_n;
    logic        valid_n;

    assign pc_plus4 = pc + 32'd4;
    assign im_addr  = pc;
    assign halted   = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            id_inst     <= '0;
            id_pc4      <= '0;
            id_valid    <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            id_inst     <= inst_n;
            id_pc4      <= pc4_n;
            id_valid    <= valid_n;
            fetch_count <= count_n;
        end
    end

    // Redirect beats stall; a halted stage only drains its IF/ID valid bit.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        inst_n  = id_inst;
        pc4_n   = id_pc4;
        valid_n = id_valid;
        count_n = fetch_count;
        if (redirect) begin
            pc_n    = {redirect_pc[31:2], 2'b00};
            valid_n = 1'b0;
            state_n = RUN;
        end else if (stall) begin
            state_n = state;
        end else if (state == HALT) begin
            valid_n = 1'b0;
        end else begin
            inst_n  = im_data;
            pc4_n   = pc_plus4;
            valid_n = 1'b1;
            count_n = fetch_count + 32'd1;
            if (im_data == BREAK_WORD) begin
                state_n = HALT;
            end else begin
                pc_n = pc_plus4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async reset in HALT,
// then randomized traffic against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] BRK = 32'h0000_000D;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [64];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign im_data = mem[im_addr[7:2]];

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .im_addr(im_addr), .im_data(im_data),
        .id_inst(id_inst), .id_pc4(id_pc4), .id_valid(id_valid),
        .halted(halted), .fetch_count(fetch_count)
    );

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] addr;
        logic        halt;
        logic [31:0] count;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] inst,
                             input logic [31:0] pc4, input logic valid,
                             input logic [31:0] addr, input logic halt,
                             input logic [31:0] count);
        check({tag, ".id_inst"}, id_inst, inst);
        check({tag, ".id_pc4"}, id_pc4, pc4);
        check({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, valid});
        check({tag, ".im_addr"}, im_addr, addr);
        check({tag, ".halted"}, {31'd0, halted}, {31'd0, halt});
        check({tag, ".fetch_count"}, fetch_count, count);
    endtask

    task automatic step(input logic s, input logic r, input logic [31:0] rp);
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stall = 0; redirect = 0; redirect_pc = 0;
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    // Reference model state
    logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
    logic        m_valid, m_halt;

    task automatic model_reset();
        m_pc = 0; m_inst = 0; m_pc4 = 0; m_cnt = 0;
        m_valid = 0; m_halt = 0;
    endtask

    task automatic model_step(input logic s, input logic r,
                              input logic [31:0] rp);
        if (r) begin
            m_pc    = rp & ~32'd3;
            m_valid = 0;
            m_halt  = 0;
        end else if (s) begin
            m_valid = m_valid;
        end else if (m_halt) begin
            m_valid = 0;
        end else begin
            m_inst  = mem[m_pc[7:2]];
            m_pc4   = m_pc + 4;
            m_valid = 1;
            m_cnt   = m_cnt + 1;
            if (m_inst == BRK) m_halt = 1;
            else m_pc = m_pc + 4;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | (i * 4);
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = BRK;

        //          st re rpc           inst          pc4           v  addr          h  cnt
        vecs[0]  = '{0, 0, 32'h0,        32'h11,       32'h4,        1, 32'h4,        0, 1};
        vecs[1]  = '{0, 0, 32'h0,        32'h22,       32'h8,        1, 32'h8,        0, 2};
        vecs[2]  = '{1, 0, 32'h0,        32'h22,       32'h8,        1, 32'h8,        0, 2};
        vecs[3]  = '{1, 0, 32'h0,        32'h22,       32'h8,        1, 32'h8,        0, 2};
        vecs[4]  = '{0, 0, 32'h0,        32'h33,       32'hC,        1, 32'hC,        0, 3};
        vecs[5]  = '{0, 0, 32'h0,        BRK,          32'h10,       1, 32'hC,        1, 4};
        vecs[6]  = '{0, 0, 32'h0,        BRK,          32'h10,       0, 32'hC,        1, 4};
        vecs[7]  = '{0, 0, 32'h0,        BRK,          32'h10,       0, 32'hC,        1, 4};
        vecs[8]  = '{0, 1, 32'h0,        BRK,          32'h10,       0, 32'h0,        0, 4};
        vecs[9]  = '{0, 0, 32'h0,        32'h11,       32'h4,        1, 32'h4,        0, 5};
        vecs[10] = '{1, 1, 32'h43,       32'h11,       32'h4,        0, 32'h40,       0, 5};
        vecs[11] = '{0, 0, 32'h0,        32'hA000_0040, 32'h44,      1, 32'h44,       0, 6};
        vecs[12] = '{0, 1, 32'hFFFF_FFFF, 32'hA000_0040, 32'h44,     0, 32'hFFFF_FFFC, 0, 6};
        vecs[13] = '{0, 0, 32'h0,        32'hA000_00FC, 32'h0,       1, 32'h0,        0, 7};
        vecs[14] = '{0, 0, 32'h0,        32'h11,       32'h4,        1, 32'h4,        0, 8};

        do_reset();
        check_all("reset", 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
            check_all($sformatf("vec%0d", i), vecs[i].inst, vecs[i].pc4,
                      vecs[i].valid, vecs[i].addr, vecs[i].halt, vecs[i].count);
        end

        // Reach HALT with fetch_count=5, then async reset between edges
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        step(0, 1, 32'hC);
        step(0, 0, 0);
        check_all("halt5", BRK, 32'h10, 1, 32'hC, 1, 32'd5);
        #2;
        rst_n = 0;
        #1;
        check_all("async_rst", 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        @(posedge clk);
        #1;
        check_all("rst_hold", 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        rst_n = 1;

        // Randomized traffic against the model
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 9) == 0) ? BRK : $urandom;
        do_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            logic s, r;
            logic [31:0] rp;
            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 9) == 0);
            rp = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFE : $urandom_range(0, 255);
            step(s, r, rp);
            model_step(s, r, rp);
            check_all($sformatf("rnd%0d", n), m_inst, m_pc4, m_valid,
                      m_pc, m_halt, m_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
